demux_scan_ctrl_lxy: RTL and testbench

//  Time-multiplexed scan controller for the 3-8 data demux (sel/data_in/en).

---
 rtl/demux_scan_pkg.sv | 20 ++
 rtl/demux_scan_ctrl_lxy_rr_next_sel.sv | 32 +++
 rtl/demux_scan_ctrl_lxy.sv | 142 ++++++++++++++
 tb/tb_demux_scan_ctrl_lxy.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux_scan_pkg.sv
// Shared types and constants for the 3-8 demux scan controller.
// Channel k of a frame occupies bits [k*DW +: DW].
package demux_scan_pkg;

  localparam int DW   = 4;
  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic [DW-1:0] ch_slice(input logic [NCH*DW-1:0] frame,
                                             input logic [SELW-1:0]   k);
    return frame[k*DW +: DW];
  endfunction

endpackage

// File: rtl/demux_scan_ctrl_lxy_rr_next_sel.sv
// Combinational round-robin search: next set mask bit after cur_sel (mod NCH).
// A lone set bit at cur_sel finds itself, which counts as a wrap.
module rr_next_sel #(
  parameter int NCH  = 8,
  parameter int SELW = 3
) (
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] cur_sel,
  output logic [SELW-1:0] next_sel,
  output logic            wrapped,
  output logic            none
);

  logic            found;
  logic [SELW-1:0] idx;

  always_comb begin
    next_sel = cur_sel;
    found    = 1'b0;
    idx      = '0;
    none     = (mask == '0);
    for (int i = 1; i <= NCH; i++) begin
      idx = SELW'((int'(cur_sel) + i) % NCH);
      if (!found && mask[idx]) begin
        next_sel = idx;
        found    = 1'b1;
      end
    end
    wrapped = !none && (next_sel <= cur_sel);
  end

endmodule

// File: rtl/demux_scan_ctrl_lxy.sv
// Scan controller: walks the enabled channels onto the demux, DWELL clocks each,
// with a 1-clock blanking gap; frame reloads take effect only at frame boundaries.
module demux_scan_ctrl_lxy
  import demux_scan_pkg::*;
#(
  parameter int DWELL = 250,
  parameter int CW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stop,
  input  logic [NCH-1:0]      ch_mask,
  input  logic [NCH*DW-1:0]   frame_data,
  input  logic                load_req,
  output logic                load_ack,
  output logic [SELW-1:0]     dmx_sel,
  output logic [DW-1:0]       dmx_data,
  output logic                dmx_en,
  output logic                frame_done,
  output logic                busy
);

  state_t              state_q, state_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic [DW-1:0]       data_q, data_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NCH*DW-1:0]   shadow_q, shadow_d;
  logic [NCH*DW-1:0]   pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic                req_seen_q, req_seen_d;
  logic                load_ack_q, load_ack_d;

  logic [SELW-1:0]     rr_cur, rr_next;
  logic                rr_wrapped, rr_none;
  logic                capture, boundary;

  // From IDLE the search starts below channel 0 so it yields the lowest set bit.
  assign rr_cur = (state_q == ST_IDLE) ? SELW'(NCH - 1) : sel_q;

  rr_next_sel #(.NCH(NCH), .SELW(SELW)) u_rr (
    .mask     (ch_mask),
    .cur_sel  (rr_cur),
    .next_sel (rr_next),
    .wrapped  (rr_wrapped),
    .none     (rr_none)
  );

  assign capture  = load_req && !req_seen_q;
  assign boundary = (state_q == ST_GAP) && rr_wrapped;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    req_seen_d   = load_req;
    load_ack_d   = 1'b0;

    // Boundary consumes the old pending before a same-clock capture refills it.
    if (boundary && pend_valid_q) begin
      shadow_d     = pend_q;
      pend_valid_d = 1'b0;
    end
    if (capture) begin
      load_ack_d = 1'b1;
      if (state_q == ST_IDLE) begin
        shadow_d = frame_data;
      end else begin
        pend_d       = frame_data;
        pend_valid_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && (|ch_mask) && !stop) begin
          state_d = ST_SCAN;
          sel_d   = rr_next;
          cnt_d   = '0;
          data_d  = ch_slice(shadow_d, rr_next);
        end
      end
      ST_SCAN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(DWELL - 1)) begin
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (stop || rr_none) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SCAN;
          sel_d   = rr_next;
          cnt_d   = '0;
          data_d  = ch_slice(shadow_d, rr_next);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      req_seen_q   <= 1'b0;
      load_ack_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      req_seen_q   <= req_seen_d;
      load_ack_q   <= load_ack_d;
    end
  end

  assign load_ack   = load_ack_q;
  assign dmx_sel    = sel_q;
  assign dmx_data   = data_q;
  assign dmx_en     = (state_q == ST_SCAN);
  assign busy       = (state_q != ST_IDLE);
  // A reset landing on a wrap GAP suppresses that frame end.
  assign frame_done = boundary && !rst;

endmodule

// File: tb/tb_demux_scan_ctrl_lxy.sv
// Directed bench for demux_scan_ctrl_lxy with DWELL=4: table-driven scan vectors
// plus hand-written sequences for reload, stop, reset and handshake corners.
module tb_demux_scan_ctrl_lxy;

  logic        clk = 1'b0;
  logic        rst, start, stop, load_req;
  logic [7:0]  ch_mask;
  logic [31:0] frame_data;
  logic        load_ack, dmx_en, frame_done, busy;
  logic [2:0]  dmx_sel;
  logic [3:0]  dmx_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int ack_cnt;

  always #5 clk = ~clk;

  demux_scan_ctrl_lxy #(.DWELL(4), .CW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .ch_mask    (ch_mask),
    .frame_data (frame_data),
    .load_req   (load_req),
    .load_ack   (load_ack),
    .dmx_sel    (dmx_sel),
    .dmx_data   (dmx_data),
    .dmx_en     (dmx_en),
    .frame_done (frame_done),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] mask;
    logic       start;
    logic       stop;
    logic       en;
    logic [2:0] sel;
    logic [3:0] data;
    logic       fd;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic [7:0] m, input logic s, input logic p,
                     input logic e, input logic [2:0] sl, input logic [3:0] d,
                     input logic f, input logic b);
    vec_t v;
    v.mask = m; v.start = s; v.stop = p; v.en = e;
    v.sel = sl; v.data = d; v.fd = f; v.busy = b;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full frame with mask 8'hFF; optional mid-frame load at cycle load_at.
  task automatic frame_ff(input logic [31:0] fexp, input int load_at, input logic [31:0] lval);
    int k, ph;
    for (int e = 1; e <= 40; e++) begin
      cyc();
      k  = (e - 1) / 5;
      ph = (e - 1) % 5;
      chk("ff_en", 32'(dmx_en), 32'(ph < 4));
      chk("ff_sel", 32'(dmx_sel), 32'(k));
      if (ph < 4) chk("ff_data", 32'(dmx_data), 32'(fexp[k*4 +: 4]));
      chk("ff_frame_done", 32'(frame_done), 32'(ph == 4 && k == 7));
      start = 1'b0;
      if (load_at != 0) begin
        if (e == load_at) begin
          load_req   = 1'b1;
          frame_data = lval;
        end
        if (e == load_at + 1) begin
          chk("ff_ack_pulse", 32'(load_ack), 32'd1);
          load_req = 1'b0;
        end
        if (e == load_at + 2) chk("ff_ack_drop", 32'(load_ack), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; load_req = 1'b0;
    ch_mask = 8'h00; frame_data = 32'h0;

    // Reset state
    cyc(); cyc();
    chk("rst_sel", 32'(dmx_sel), 32'd0);
    chk("rst_data", 32'(dmx_data), 32'd0);
    chk("rst_en", 32'(dmx_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_ack", 32'(load_ack), 32'd0);
    rst = 1'b0;

    // Load in IDLE, then full-mask scan
    frame_data = 32'h76543210; load_req = 1'b1;
    cyc();
    chk("idle_ack", 32'(load_ack), 32'd1);
    load_req = 1'b0;
    cyc();
    ch_mask = 8'hFF; start = 1'b1;
    frame_ff(32'h76543210, 0, 32'h0);
    // Mid-frame reload: old data holds until the boundary
    frame_ff(32'h76543210, 12, 32'hFEDCBA98);
    frame_ff(32'hFEDCBA98, 0, 32'h0);

    // stop at dwell count 2
    cyc(); cyc(); cyc();
    chk("pre_stop_en", 32'(dmx_en), 32'd1);
    chk("pre_stop_data", 32'(dmx_data), 32'd8);
    stop = 1'b1;
    cyc();
    chk("stop_en", 32'(dmx_en), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    start = 1'b1;
    cyc();
    chk("start_stop_busy", 32'(busy), 32'd0);
    chk("start_stop_en", 32'(dmx_en), 32'd0);
    start = 1'b0; stop = 1'b0;

    // IDLE load takes effect immediately
    frame_data = 32'h76543210; load_req = 1'b1;
    cyc();
    chk("idle_ack2", 32'(load_ack), 32'd1);
    load_req = 1'b0;
    cyc();
    chk("idle_ack2_drop", 32'(load_ack), 32'd0);

    // Sparse mask 2,5,7 then mask cleared mid-scan
    add(1, 8'hA4, 1, 0, 1, 2, 2, 0, 1);
    add(3, 8'hA4, 0, 0, 1, 2, 2, 0, 1);
    add(1, 8'hA4, 0, 0, 0, 2, 2, 0, 1);
    add(4, 8'hA4, 0, 0, 1, 5, 5, 0, 1);
    add(1, 8'hA4, 0, 0, 0, 5, 5, 0, 1);
    add(4, 8'hA4, 0, 0, 1, 7, 7, 0, 1);
    add(1, 8'hA4, 0, 0, 0, 7, 7, 1, 1);
    add(4, 8'hA4, 0, 0, 1, 2, 2, 0, 1);
    add(1, 8'hA4, 0, 0, 0, 2, 2, 0, 1);
    add(1, 8'hA4, 0, 0, 1, 5, 5, 0, 1);
    add(3, 8'h00, 0, 0, 1, 5, 5, 0, 1);
    add(1, 8'h00, 0, 0, 0, 5, 5, 0, 1);
    add(1, 8'h00, 0, 0, 0, 5, 5, 0, 0);
    foreach (tbl[i]) begin
      ch_mask = tbl[i].mask; start = tbl[i].start; stop = tbl[i].stop;
      cyc();
      chk($sformatf("tbl%0d_en", i), 32'(dmx_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_sel", i), 32'(dmx_sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_data", i), 32'(dmx_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_fd", i), 32'(frame_done), 32'(tbl[i].fd));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
    end
    start = 1'b0;

    // Single channel: every GAP is a frame end; reset during GAP
    ch_mask = 8'h10; start = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cyc();
      start = 1'b0;
      if (e == 1) chk("single_sel", 32'(dmx_sel), 32'd4);
      if (e == 1) chk("single_data", 32'(dmx_data), 32'd4);
      if (e == 5) chk("single_fd", 32'(frame_done), 32'd1);
      if (e == 5) chk("single_gap_sel", 32'(dmx_sel), 32'd4);
    end
    rst = 1'b1;
    #1;
    chk("rst_gap_fd", 32'(frame_done), 32'd0);
    cyc();
    chk("rst2_sel", 32'(dmx_sel), 32'd0);
    chk("rst2_data", 32'(dmx_data), 32'd0);
    chk("rst2_en", 32'(dmx_en), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Held request, then load coinciding with a frame boundary (mask ch4,ch5)
    ch_mask = 8'h30; start = 1'b1; ack_cnt = 0;
    for (int s = 1; s <= 41; s++) begin
      cyc();
      start = 1'b0;
      if (s >= 12 && s <= 22 && load_ack) ack_cnt++;
      case (s)
        1:  begin chk("r_sel", 32'(dmx_sel), 32'd4); chk("r_data", 32'(dmx_data), 32'd0); end
        11: chk("h_data11", 32'(dmx_data), 32'd0);
        20, 30, 40: chk($sformatf("h_fd%0d", s), 32'(frame_done), 32'd1);
        21: chk("h_data21", 32'(dmx_data), 32'd1);
        26: chk("h_data26", 32'(dmx_data), 32'd2);
        31: begin chk("h_data31", 32'(dmx_data), 32'd3); chk("h_ack31", 32'(load_ack), 32'd1); end
        36: chk("h_data36", 32'(dmx_data), 32'd4);
        41: begin chk("h_data41", 32'(dmx_data), 32'd5); chk("h_sel41", 32'(dmx_sel), 32'd4); end
        default: ;
      endcase
      case (s)
        11: begin load_req = 1'b1; frame_data = 32'h0021_0000; end
        21: load_req = 1'b0;
        23: begin load_req = 1'b1; frame_data = 32'h0043_0000; end
        24: load_req = 1'b0;
        30: begin load_req = 1'b1; frame_data = 32'h0065_0000; end
        31: load_req = 1'b0;
        default: ;
      endcase
    end
    chk("held_ack_count", 32'(ack_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
